// File: rtl/step_pulse_gen_pkg.sv
// step_gen_pkg: shared types and constants for the step-pulse generator.
//   step_state_t : move sequencer states
//   P_N..P_DELTA : word indices into the five-word move parameter bus
package step_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } step_state_t;

  localparam int unsigned P_N     = 0;  // total steps
  localparam int unsigned P_NN    = 1;  // acceleration steps
  localparam int unsigned P_T0    = 2;  // maximum (starting) period
  localparam int unsigned P_TNA   = 3;  // cruise period
  localparam int unsigned P_DELTA = 4;  // per-step period change

endpackage

// File: rtl/step_pulse_gen_period_timer.sv
// period_timer: plays one step period at a time.
//   clk, reset (sync, active-low)
//   load     : start a new period of length `period` (takes priority, may
//              coincide with expire for back-to-back periods)
//   period   : period length in clocks, must exceed PULSE_W
//   pulse_on : high during the first PULSE_W clocks of the period
//   expire   : high during the last clock of the period
module period_timer #(
  parameter int unsigned PULSE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] period,
  output logic        pulse_on,
  output logic        expire
);

  logic [31:0] idx_q, idx_d;
  logic [31:0] per_q, per_d;
  logic        active_q, active_d;

  assign pulse_on = active_q && (idx_q < 32'(PULSE_W));
  assign expire   = active_q && (idx_q == (per_q - 32'd1));

  always_comb begin
    idx_d    = idx_q;
    per_d    = per_q;
    active_d = active_q;
    if (load) begin
      idx_d    = '0;
      per_d    = period;
      active_d = 1'b1;
    end else if (expire) begin
      active_d = 1'b0;
    end else if (active_q) begin
      idx_d = idx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q    <= '0;
      per_q    <= '0;
      active_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      per_q    <= per_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: plays a trapezoidal/triangular move as a train of step
// pulses on one stepper axis.
//   clk, reset (sync, active-low)
//   start        : level; high runs the move, low aborts/clears
//   timing_ready : upstream calculator finished; gates the launch only
//   params[0:4]  : N, nn, t0, tna, delta
//   step         : registered step pulse, PULSE_W clocks high per period
//   busy         : high in LOAD/ACCEL/CRUISE/DECEL
//   done         : move complete, held until start falls
//   step_count   : pulses issued in this move
//   elapsed      : clocks from first step rise to done rise
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned MIN_PERIOD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        timing_ready,
  input  logic [31:0] params [0:4],
  output logic        step,
  output logic        busy,
  output logic        done,
  output logic [31:0] step_count,
  output logic [63:0] elapsed
);

  step_state_t state_q, state_d;
  logic [31:0] n_q, n_d, nn_q, nn_d, t0_q, t0_d, tna_q, tna_d, delta_q, delta_d;
  logic [31:0] k_q, k_d;
  logic        fin_q, fin_d;
  logic        step_q, step_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] step_count_q, step_count_d;
  logic [63:0] elapsed_q, elapsed_d;

  logic [32:0] two_nn;
  logic        long_move;
  logic [31:0] accel_n, mid_n, mid_base, mid_mult;
  logic [31:0] sel_base, sel_mult, tmr_period;
  logic        tmr_load, tmr_pulse_on, tmr_expire;
  logic        run;

  // base - mult*delta, saturating at 0, then floored at MIN_PERIOD.
  function automatic logic [31:0] sat_period(input logic [31:0] base,
                                             input logic [31:0] mult,
                                             input logic [31:0] dlt);
    logic [63:0] prod;
    logic [31:0] p;
    prod = 64'(mult) * 64'(dlt);
    if (prod >= 64'(base)) p = '0;
    else                   p = base - prod[31:0];
    if (p < 32'(MIN_PERIOD)) p = 32'(MIN_PERIOD);
    return p;
  endfunction

  // Params are latched on the IDLE->LOAD edge, so the segment lengths below
  // are stable from LOAD onwards and need no registers of their own.
  assign two_nn    = {nn_q, 1'b0};
  assign long_move = {1'b0, n_q} > two_nn;
  assign accel_n   = long_move ? nn_q : (n_q >> 1);
  assign mid_n     = long_move ? (n_q - nn_q - nn_q) : {31'd0, n_q[0]};
  assign mid_base  = long_move ? tna_q : t0_q;
  assign mid_mult  = long_move ? '0 : accel_n;
  assign run       = state_q inside {S_ACCEL, S_CRUISE, S_DECEL};

  assign tmr_period = sat_period(sel_base, sel_mult, delta_q);

  period_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .period   (tmr_period),
    .pulse_on (tmr_pulse_on),
    .expire   (tmr_expire)
  );

  // Sequencer. The timer runs one clock ahead of the registered step, so the
  // final expire sets fin_q and DONE follows one clock later, keeping done
  // exactly one full period after the last step rise.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    nn_d     = nn_q;
    t0_d     = t0_q;
    tna_d    = tna_q;
    delta_d  = delta_q;
    k_d      = k_q;
    fin_d    = fin_q;
    tmr_load = 1'b0;
    sel_base = t0_q;
    sel_mult = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start && timing_ready) begin
          state_d = S_LOAD;
          n_d     = params[P_N];
          nn_d    = params[P_NN];
          t0_d    = params[P_T0];
          tna_d   = params[P_TNA];
          delta_d = params[P_DELTA];
          k_d     = '0;
          fin_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accel_n != '0) begin
          state_d  = S_ACCEL;
          tmr_load = 1'b1;
          k_d      = 32'd1;
        end else if (mid_n != '0) begin
          state_d  = S_CRUISE;
          tmr_load = 1'b1;
          sel_base = mid_base;
          sel_mult = mid_mult;
          k_d      = 32'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ACCEL: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          k_d      = 32'd1;
          if (k_q < accel_n) begin
            sel_mult = k_q;
            k_d      = k_q + 32'd1;
          end else if (mid_n != '0) begin
            state_d  = S_CRUISE;
            sel_base = mid_base;
            sel_mult = mid_mult;
          end else begin
            state_d  = S_DECEL;
            sel_mult = accel_n - 32'd1;
          end
        end
      end
      S_CRUISE: begin
        if (fin_q) begin
          state_d = S_DONE;
        end else if (tmr_expire) begin
          if (k_q < mid_n) begin
            tmr_load = 1'b1;
            sel_base = mid_base;
            sel_mult = mid_mult;
            k_d      = k_q + 32'd1;
          end else if (accel_n != '0) begin
            state_d  = S_DECEL;
            tmr_load = 1'b1;
            sel_mult = accel_n - 32'd1;
            k_d      = 32'd1;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_DECEL: begin
        if (fin_q) begin
          state_d = S_DONE;
        end else if (tmr_expire) begin
          if (k_q < accel_n) begin
            tmr_load = 1'b1;
            sel_mult = accel_n - 32'd1 - k_q;
            k_d      = k_q + 32'd1;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!start) begin
      state_d  = S_IDLE;
      tmr_load = 1'b0;
      fin_d    = 1'b0;
    end
  end

  always_comb begin
    step_d       = start && run && tmr_pulse_on;
    step_count_d = step_count_q;
    elapsed_d    = elapsed_q;
    if (!start) begin
      step_count_d = '0;
      elapsed_d    = '0;
    end else begin
      if (step_d && !step_q) step_count_d = step_count_q + 32'd1;
      if (run && (step_count_q != '0)) elapsed_d = elapsed_q + 64'd1;
    end
    busy_d = state_d inside {S_LOAD, S_ACCEL, S_CRUISE, S_DECEL};
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      nn_q         <= '0;
      t0_q         <= '0;
      tna_q        <= '0;
      delta_q      <= '0;
      k_q          <= '0;
      fin_q        <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_count_q <= '0;
      elapsed_q    <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      nn_q         <= nn_d;
      t0_q         <= t0_d;
      tna_q        <= tna_d;
      delta_q      <= delta_d;
      k_q          <= k_d;
      fin_q        <= fin_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_count_q <= step_count_d;
      elapsed_q    <= elapsed_d;
    end
  end

  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_count = step_count_q;
  assign elapsed    = elapsed_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboarded bench for step_pulse_gen. For each move the driver pushes the
// expected event intervals (launch->first rise, then each period, the last
// one measured to done) and the expected final counters; a monitor measures
// the DUT's events on the falling edge and compares.
module tb_step_pulse_gen;

  localparam int unsigned PULSE_W    = 4;
  localparam int unsigned MIN_PERIOD = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic        timing_ready;
  logic [31:0] params [0:4];
  logic        step;
  logic        busy;
  logic        done;
  logic [31:0] step_count;
  logic [63:0] elapsed;

  step_pulse_gen #(
    .PULSE_W    (PULSE_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .timing_ready (timing_ready),
    .params       (params),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .step_count   (step_count),
    .elapsed      (elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  longint exp_int [$];
  longint exp_cnt [$];
  longint exp_el  [$];

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Period of the i-th pulse (0-based) from the move rules, clamped.
  function automatic longint ref_period(longint i, longint n, longint nn,
                                        longint t0, longint tna, longint dl);
    longint a, p;
    a = (n > 2 * nn) ? nn : n / 2;
    if (i < a)               p = t0 - i * dl;
    else if (i >= n - a)     p = t0 - (n - 1 - i) * dl;
    else if (n > 2 * nn)     p = tna;
    else                     p = t0 - a * dl;
    if (p < MIN_PERIOD) p = MIN_PERIOD;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes expectations for one move; returns the expected elapsed time.
  task automatic push_expect(input int unsigned n, nn, t0, tna, dl, output longint sum);
    longint p;
    sum = 0;
    exp_int.push_back((n == 0) ? 1 : 2);
    for (int unsigned i = 0; i < n; i++) begin
      p = ref_period(i, n, nn, t0, tna, dl);
      exp_int.push_back(p);
      sum += p;
    end
    exp_cnt.push_back(n);
    exp_el.push_back(sum);
  endtask

  task automatic set_params(input int unsigned n, nn, t0, tna, dl);
    params[0] = n;
    params[1] = nn;
    params[2] = t0;
    params[3] = tna;
    params[4] = dl;
  endtask

  task automatic launch();
    int c;
    start = 1'b1;
    repeat ($urandom_range(0, 3)) tick();
    timing_ready = 1'b1;
    c = 0;
    while (!busy && c < 10) begin tick(); c++; end
    chk("launch_busy", busy, 1);
    timing_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic flush();
    exp_int.delete();
    exp_cnt.delete();
    exp_el.delete();
  endtask

  task automatic run_move(input int unsigned n, nn, t0, tna, dl);
    longint sum;
    int c;
    set_params(n, nn, t0, tna, dl);
    push_expect(n, nn, t0, tna, dl, sum);
    launch();
    c = 0;
    while (!done && c < int'(sum) + 40) begin tick(); c++; end
    chk("done_reached", done, 1);
    repeat ($urandom_range(1, 4)) tick();
    chk("done_held", done, 1);
    chk("final_count", step_count, n);
    chk("queue_drained", exp_int.size() + exp_cnt.size(), 0);
    start = 1'b0;
    timing_ready = 1'b0;
    tick();
    chk("clear_done", done, 0);
    chk("clear_busy", busy, 0);
    chk("clear_count", step_count, 0);
    chk("clear_elapsed", elapsed, 0);
    flush();
    tick();
  endtask

  // Monitor: each launch, step rise and done rise is an event; the interval
  // since the previous event is popped from the scoreboard and compared.
  logic   prev_step = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  int     mark = 0;
  logic   mark_valid = 1'b0;
  int     hi_len = 0;

  task automatic take_interval();
    longint e;
    chk("mark_valid", mark_valid, 1);
    chk("event_expected", (exp_int.size() != 0), 1);
    if (exp_int.size() != 0) begin
      e = exp_int.pop_front();
      chk("interval", cyc - mark, e);
    end
    mark = cyc;
    mark_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset || (!busy && !done)) mark_valid = 1'b0;
      if (reset) begin
        if (busy && !prev_busy && !prev_done) begin
          mark = cyc;
          mark_valid = 1'b1;
        end
        if (step && !prev_step) begin
          hi_len = 1;
          take_interval();
        end else if (step) begin
          hi_len++;
        end
        if (!step && prev_step && busy) chk("pulse_width", hi_len, PULSE_W);
        if (done && !prev_done) begin
          take_interval();
          chk("busy_at_done", busy, 0);
          chk("summary_expected", (exp_cnt.size() != 0), 1);
          if (exp_cnt.size() != 0) begin
            chk("step_count", step_count, exp_cnt.pop_front());
            chk("elapsed", elapsed, exp_el.pop_front());
          end
          mark_valid = 1'b0;
        end
      end
      prev_step = step;
      prev_busy = busy;
      prev_done = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sum;
    int c;
    int dones;
    reset = 1'b0;
    start = 1'b0;
    timing_ready = 1'b0;
    set_params(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", step_count, 0);
    chk("rst_elapsed", elapsed, 0);
    reset = 1'b1;
    tick();

    run_move(10, 3, 40, 20, 4);   // trapezoid, elapsed 296
    run_move(5, 3, 40, 20, 4);    // triangle, odd N, elapsed 184
    run_move(0, 0, 40, 20, 4);    // empty move
    run_move(1, 0, 40, 25, 4);    // single cruise pulse, elapsed 25
    run_move(6, 3, 10, 20, 4);    // clamp/saturation 10,8,8,8,8,10

    // Abort during the 4th (cruise) period, then relaunch the same move.
    set_params(10, 3, 40, 20, 4);
    push_expect(10, 3, 40, 20, 4, sum);
    launch();
    c = 0;
    while (step_count != 4 && c < 500) begin tick(); c++; end
    chk("abort_reach4", step_count, 4);
    repeat ($urandom_range(1, 15)) tick();
    @(negedge clk);
    #1;
    flush();
    start = 1'b0;
    timing_ready = 1'b0;
    tick();
    chk("abort_step", step, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", step_count, 0);
    chk("abort_elapsed", elapsed, 0);
    tick();
    run_move(10, 3, 40, 20, 4);

    // Reset during DECEL with start held high.
    set_params(10, 3, 40, 20, 4);
    push_expect(10, 3, 40, 20, 4, sum);
    launch();
    c = 0;
    while (step_count != 8 && c < 500) begin tick(); c++; end
    chk("reset_reach8", step_count, 8);
    repeat ($urandom_range(1, 20)) tick();
    @(negedge clk);
    #1;
    flush();
    reset = 1'b0;
    timing_ready = 1'b0;
    tick();
    chk("mreset_step", step, 0);
    chk("mreset_busy", busy, 0);
    chk("mreset_done", done, 0);
    chk("mreset_count", step_count, 0);
    chk("mreset_elapsed", elapsed, 0);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) dones++;
    end
    chk("no_done_after_reset", dones, 0);
    start = 1'b0;
    tick();

    // Randomized moves.
    for (int r = 0; r < 10; r++) begin
      run_move($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(8, 40),
               $urandom_range(3, 30), $urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
